// File: rtl/hk_sram_ro_reader.sv
// hk_sram_ro_reader: reads a burst of 32-bit words from the management SRAM
// read-only port and returns them as an MSB-first byte stream.
//
// Byte stream handshake: a byte moves when byte_valid && byte_ready are both
// high at a rising core_clk edge. byte_data/byte_last are held while
// byte_valid=1 and byte_ready=0. The request side uses the same rule with
// req_valid/req_ready, and req_ready is high only in IDLE.
module hk_sram_ro_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 9
) (
    input  logic                  core_clk,
    input  logic                  core_rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [CNT_WIDTH-1:0]  req_count,
    input  logic                  abort,
    output logic                  sram_ro_clk,
    output logic                  sram_ro_csb,
    output logic [ADDR_WIDTH-1:0] sram_ro_addr,
    input  logic [31:0]           sram_ro_data,
    output logic                  byte_valid,
    output logic [7:0]            byte_data,
    output logic                  byte_last,
    input  logic                  byte_ready,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        CLK_HI = 3'd2,
        CLK_LO = 3'd3,
        SHIFT  = 3'd4,
        FIN    = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic                  clk_q, clk_d;
    logic                  csb_q, csb_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;
    logic [31:0]           word_q, word_d;
    logic [1:0]            idx_q, idx_d;

    logic accept;
    logic byte_hs;
    logic word_done;
    logic on_last_word;

    assign accept       = (state_q == IDLE) && req_valid;
    assign byte_hs      = (state_q == SHIFT) && byte_ready;
    assign word_done    = byte_hs && (idx_q == 2'd3);
    assign on_last_word = (rem_q == CNT_WIDTH'(1));

    // State and datapath registers; strobe/select outputs come straight from flops
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state_q <= IDLE;
            clk_q   <= 1'b0;
            csb_q   <= 1'b1;
            addr_q  <= '0;
            rem_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            clk_q   <= clk_d;
            csb_q   <= csb_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic; abort overrides everything except in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (req_count == '0) ? FIN : SETUP;
            SETUP:   state_d = CLK_HI;
            CLK_HI:  state_d = CLK_LO;
            CLK_LO:  state_d = SHIFT;
            SHIFT:   if (word_done) state_d = on_last_word ? FIN : SETUP;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // Next values for the registered SRAM strobes and the burst datapath
    always_comb begin
        clk_d  = (state_d == CLK_HI);
        csb_d  = !((state_d == SETUP) || (state_d == CLK_HI));
        addr_d = addr_q;
        rem_d  = rem_q;
        word_d = word_q;
        idx_d  = idx_q;
        if (accept) begin
            addr_d = req_addr;
            rem_d  = req_count;
        end
        if (!abort) begin
            // SRAM output is valid during CLK_LO; capture it on the way into SHIFT
            if (state_q == CLK_LO) begin
                word_d = sram_ro_data;
                idx_d  = 2'd0;
            end
            if (byte_hs) begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    rem_d  = rem_q - CNT_WIDTH'(1);
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Byte-stream outputs decoded from the current state and byte index
    always_comb begin
        byte_data = 8'h00;
        if (state_q == SHIFT) begin
            unique case (idx_q)
                2'd0:    byte_data = word_q[31:24];
                2'd1:    byte_data = word_q[23:16];
                2'd2:    byte_data = word_q[15:8];
                default: byte_data = word_q[7:0];
            endcase
        end
    end

    assign byte_valid   = (state_q == SHIFT);
    assign byte_last    = (state_q == SHIFT) && (idx_q == 2'd3) && on_last_word;
    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FIN);
    assign sram_ro_clk  = clk_q;
    assign sram_ro_csb  = csb_q;
    assign sram_ro_addr = addr_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_hk_sram_ro_reader.sv
// Directed bench for hk_sram_ro_reader with an SRAM model and byte scoreboard.
module tb_hk_sram_ro_reader;

    logic       core_clk;
    logic       core_rstn;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic [8:0] req_count;
    logic       abort;
    logic       sram_ro_clk;
    logic       sram_ro_csb;
    logic [7:0] sram_ro_addr;
    logic [31:0] sram_ro_data;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       byte_ready;
    logic       busy;
    logic       done;
    logic [2:0] state_dbg;

    int tests_run = 0;
    int fails     = 0;
    int bytes_seen = 0;

    logic [8:0]  exp_q[$];       // {last, byte}
    logic [7:0]  exp_addr_q[$];
    bit          addr_chk_en = 0;

    logic [31:0] mem [256];
    logic [31:0] sram_q;

    hk_sram_ro_reader #(.ADDR_WIDTH(8), .CNT_WIDTH(9)) dut (
        .core_clk     (core_clk),
        .core_rstn    (core_rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_count    (req_count),
        .abort        (abort),
        .sram_ro_clk  (sram_ro_clk),
        .sram_ro_csb  (sram_ro_csb),
        .sram_ro_addr (sram_ro_addr),
        .sram_ro_data (sram_ro_data),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_last    (byte_last),
        .byte_ready   (byte_ready),
        .busy         (busy),
        .done         (done),
        .state_dbg    (state_dbg)
    );

    // clock
    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    // SRAM read port model: samples csb/addr on rising sram_ro_clk
    always @(posedge sram_ro_clk) begin
        if (!sram_ro_csb) sram_q <= mem[sram_ro_addr];
    end
    assign sram_ro_data = sram_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge core_clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input bit last_word);
        exp_q.push_back({1'b0, w[31:24]});
        exp_q.push_back({1'b0, w[23:16]});
        exp_q.push_back({1'b0, w[15:8]});
        exp_q.push_back({last_word, w[7:0]});
    endtask

    // drive a request for one cycle; returns positioned in cycle T+1
    task automatic send_req(input logic [7:0] a, input logic [8:0] c);
        req_valid = 1'b1;
        req_addr  = a;
        req_count = c;
        @(negedge core_clk);
        chk("req_ready_at_accept", req_ready, 1);
        next_cycle();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge core_clk);
            if (done) begin
                seen = 1;
                break;
            end
            next_cycle();
        end
        chk(tag, seen, 1);
        next_cycle();
    endtask

    // scoreboard: compare every accepted byte, and hold stability under stall
    logic       prev_stall = 0;
    logic [8:0] prev_byte  = '0;
    always @(negedge core_clk) begin
        if (core_rstn) begin
            if (prev_stall) begin
                chk("stall_valid_held", byte_valid, 1);
                chk("stall_byte_held", {byte_last, byte_data}, prev_byte);
            end
            if (byte_valid && byte_ready && !abort) begin
                chk("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("byte_stream", {byte_last, byte_data}, exp_q.pop_front());
                bytes_seen++;
            end
            prev_stall = byte_valid && !byte_ready && !abort;
            prev_byte  = {byte_last, byte_data};
        end else begin
            prev_stall = 0;
        end
    end

    // address sequence checker for the wrap test
    always @(posedge sram_ro_clk) begin
        if (addr_chk_en) begin
            chk("sram_addr_expected", exp_addr_q.size() != 0, 1);
            if (exp_addr_q.size() != 0) chk("sram_addr", sram_ro_addr, exp_addr_q.pop_front());
        end
    end

    initial begin
        logic [31:0] w;
        logic [7:0]  eb;
        logic [31:0] w81;

        core_rstn  = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_count  = '0;
        abort      = 1'b0;
        byte_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h10] = 32'hA1B2C3D4;
        mem[8'hFE] = 32'h0000_0001;
        mem[8'hFF] = 32'h0000_0002;
        mem[8'h00] = 32'h0000_0003;

        // reset state
        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        chk("rst_csb", sram_ro_csb, 1);
        chk("rst_clk", sram_ro_clk, 0);
        chk("rst_addr", sram_ro_addr, 0);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_byte_data", byte_data, 0);
        chk("rst_byte_last", byte_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", state_dbg, 0);
        next_cycle();
        core_rstn = 1'b1;
        next_cycle();

        // single word, cycle-exact timing
        w = 32'hA1B2C3D4;
        push_word(w, 1);
        send_req(8'h10, 9'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge core_clk);
            chk("t1_csb", sram_ro_csb, (k <= 2) ? 0 : 1);
            chk("t1_clk", sram_ro_clk, (k == 2) ? 1 : 0);
            chk("t1_valid", byte_valid, (k >= 4 && k <= 7) ? 1 : 0);
            chk("t1_done", done, (k == 8) ? 1 : 0);
            chk("t1_busy", busy, 1);
            chk("t1_req_ready", req_ready, 0);
            if (k >= 4 && k <= 7) begin
                eb = 8'(w >> (8 * (7 - k)));
                chk("t1_byte", byte_data, eb);
                chk("t1_last", byte_last, (k == 7) ? 1 : 0);
            end
            if (k == 1) chk("t1_addr", sram_ro_addr, 8'h10);
            next_cycle();
        end
        @(negedge core_clk);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_done", done, 0);
        chk("t1_queue", exp_q.size(), 0);
        next_cycle();

        // address wrap FE, FF, 00
        bytes_seen = 0;
        push_word(32'h1, 0);
        push_word(32'h2, 0);
        push_word(32'h3, 1);
        exp_addr_q.push_back(8'hFE);
        exp_addr_q.push_back(8'hFF);
        exp_addr_q.push_back(8'h00);
        addr_chk_en = 1;
        send_req(8'hFE, 9'd3);
        wait_done(60, "t2_done");
        addr_chk_en = 0;
        chk("t2_bytes", bytes_seen, 12);
        chk("t2_addr_queue", exp_addr_q.size(), 0);
        chk("t2_queue", exp_q.size(), 0);

        // random backpressure, count=4
        bytes_seen = 0;
        for (int i = 0; i < 4; i++) push_word(mem[8'h40 + i], i == 3);
        send_req(8'h40, 9'd4);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 400; i++) begin
                byte_ready = 1'($urandom_range(0, 1));
                @(negedge core_clk);
                if (done) begin
                    seen = 1;
                    break;
                end
                next_cycle();
            end
            chk("t3_done", seen, 1);
        end
        next_cycle();
        byte_ready = 1'b1;
        chk("t3_bytes", bytes_seen, 16);
        chk("t3_queue", exp_q.size(), 0);

        // zero count
        req_valid = 1'b1;
        req_addr  = 8'h55;
        req_count = 9'd0;
        @(negedge core_clk);
        chk("t4_ready_before", req_ready, 1);
        next_cycle();
        req_valid = 1'b0;
        @(negedge core_clk);
        chk("t4_done", done, 1);
        chk("t4_req_ready", req_ready, 0);
        chk("t4_csb", sram_ro_csb, 1);
        chk("t4_valid", byte_valid, 0);
        next_cycle();
        @(negedge core_clk);
        chk("t4_done_clear", done, 0);
        chk("t4_req_ready_back", req_ready, 1);
        chk("t4_csb_after", sram_ro_csb, 1);
        next_cycle();

        // abort during 2nd byte of word 2 of a count=5 burst
        w81 = mem[8'h81];
        push_word(mem[8'h80], 0);
        exp_q.push_back({1'b0, w81[31:24]});
        send_req(8'h80, 9'd5);
        repeat (11) next_cycle();
        abort = 1'b1;
        @(negedge core_clk);
        chk("t5_valid_at_abort", byte_valid, 1);
        chk("t5_byte_at_abort", byte_data, w81[23:16]);
        next_cycle();
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge core_clk);
            chk("t5_busy", busy, 0);
            chk("t5_valid", byte_valid, 0);
            chk("t5_csb", sram_ro_csb, 1);
            chk("t5_clk", sram_ro_clk, 0);
            chk("t5_done", done, 0);
            chk("t5_req_ready", req_ready, 1);
            next_cycle();
        end
        chk("t5_queue_after_abort", exp_q.size(), 0);
        push_word(32'hA1B2C3D4, 1);
        send_req(8'h10, 9'd1);
        wait_done(30, "t5_retry_done");
        chk("t5_retry_queue", exp_q.size(), 0);

        // reset during CLK_HI
        send_req(8'h20, 9'd2);
        next_cycle();
        @(negedge core_clk);
        chk("t6_clk_hi", sram_ro_clk, 1);
        #1;
        core_rstn = 1'b0;
        #1;
        chk("t6_csb", sram_ro_csb, 1);
        chk("t6_clk", sram_ro_clk, 0);
        chk("t6_valid", byte_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_addr", sram_ro_addr, 0);
        next_cycle();
        core_rstn = 1'b1;
        @(negedge core_clk);
        chk("t6_req_ready", req_ready, 1);
        chk("t6_state", state_dbg, 0);
        next_cycle();

        chk("final_queue", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
